// File: rtl/cu_dac_interpolation_if.sv
// Sample-in / interpolated-sample-out bundle for cu_dac_interpolation.
// The master drives input samples and the rate. The slave (the interpolator)
// returns interpolated samples and its status flags.
interface cu_dac_interpolation_if;
    logic        drdy;      // one-cycle input-sample strobe
    logic [15:0] datain;    // signed sample, valid with drdy
    logic [2:0]  rate;      // interpolation factor N = 2^rate
    logic [15:0] dataout;   // signed interpolated sample, valid with data_rdy
    logic        data_rdy;  // one-cycle output strobe
    logic        busy;      // interpolator not idle
    logic        overrun;   // sticky: an input sample was dropped

    modport master (
        output drdy, datain, rate,
        input  dataout, data_rdy, busy, overrun
    );

    modport slave (
        input  drdy, datain, rate,
        output dataout, data_rdy, busy, overrun
    );
endinterface

// File: rtl/cu_dac_interpolation.sv
// Linear interpolator for a DAC feed.
// Each input sample starts a burst of N = 2^rate outputs that ramp linearly
// from the previous sample to the new one. Successive outputs in a burst are
// GAP clocks apart. The last output of a burst equals the new sample exactly.
// One sample arriving mid-burst is held and played once the burst ends.
// Any further mid-burst sample is dropped, and the sticky overrun flag is set.
module cu_dac_interpolation #(
    parameter int unsigned GAP = 4          // 1..255
) (
    input  logic                          clk,
    input  logic                          rst,   // asynchronous, active-low
    cu_dac_interpolation_if.slave         bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_WAIT = 2'd3;

    // The WAIT state lasts GAP-1 cycles. With GAP=1 the WAIT state is never entered.
    localparam logic [7:0] GAP_M1 = 8'(GAP - 1);

    logic [1:0]         state_q,     state_d;
    logic [15:0]        prev_q,      prev_d;
    logic [15:0]        cur_q,       cur_d;
    logic signed [16:0] diff_q,      diff_d;
    logic [7:0]         k_q,         k_d;
    logic [7:0]         gap_q,       gap_d;
    logic [2:0]         rate_l_q,    rate_l_d;
    logic [15:0]        hold_data_q, hold_data_d;
    logic               hold_vld_q,  hold_vld_d;
    logic [15:0]        dataout_q,   dataout_d;
    logic               data_rdy_q,  data_rdy_d;
    logic               overrun_q,   overrun_d;

    logic [7:0]         n_val;
    logic               last_emit;
    logic signed [24:0] prod_w;
    logic signed [24:0] shift_w;
    logic [15:0]        emit_val;

    // Interpolation datapath.
    // diff*k fits in 25 signed bits (|diff| <= 65535, k <= 128).
    // The arithmetic shift floors toward -inf.
    // The sum stays between prev and cur, so truncation to 16 bits is exact.
    always_comb begin
        n_val     = 8'd1 << rate_l_q;
        last_emit = (state_q == S_EMIT) && (k_q == n_val);
        prod_w    = 25'(diff_q) * $signed(25'(k_q));
        shift_w   = prod_w >>> rate_l_q;
        emit_val  = prev_q + 16'(shift_w);
    end

    // Next-state logic: burst sequencing, hold buffer and overrun tracking.
    always_comb begin
        // NOTE: every _d starts from its register value so no path leaves a
        // signal unassigned; that keeps this block free of inferred latches.
        state_d     = state_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        diff_d      = diff_q;
        k_d         = k_q;
        gap_d       = gap_q;
        rate_l_d    = rate_l_q;
        hold_data_d = hold_data_q;
        hold_vld_d  = hold_vld_q;
        dataout_d   = dataout_q;
        data_rdy_d  = 1'b0;
        overrun_d   = overrun_q;

        // A sample arriving mid-burst fills the one-deep hold buffer or is dropped.
        if (bus.drdy && (state_q != S_IDLE) && !last_emit) begin
            if (!hold_vld_q) begin
                hold_data_d = bus.datain;
                hold_vld_d  = 1'b1;
            end else begin
                overrun_d   = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.drdy) begin
                    cur_d    = bus.datain;
                    rate_l_d = bus.rate;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                diff_d  = 17'($signed(cur_q)) - 17'($signed(prev_q));
                k_d     = 8'd1;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                dataout_d  = emit_val;
                data_rdy_d = 1'b1;
                if (!last_emit) begin
                    k_d = k_q + 8'd1;
                    if (GAP_M1 != 8'd0) begin
                        gap_d   = GAP_M1;
                        state_d = S_WAIT;
                    end
                end else begin
                    prev_d = cur_q;
                    if (hold_vld_q) begin
                        // The held sample goes first. A coincident new sample refills the hold buffer.
                        cur_d      = hold_data_q;
                        rate_l_d   = bus.rate;
                        hold_vld_d = 1'b0;
                        state_d    = S_LOAD;
                        if (bus.drdy) begin
                            hold_data_d = bus.datain;
                            hold_vld_d  = 1'b1;
                        end
                    end else if (bus.drdy) begin
                        cur_d    = bus.datain;
                        rate_l_d = bus.rate;
                        state_d  = S_LOAD;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                gap_d = gap_q - 8'd1;
                if (gap_q == 8'd1) begin
                    state_d = S_EMIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers. Reset clears everything at once, which aborts any burst in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            prev_q      <= '0;
            cur_q       <= '0;
            diff_q      <= '0;
            k_q         <= '0;
            gap_q       <= '0;
            rate_l_q    <= '0;
            hold_data_q <= '0;
            hold_vld_q  <= 1'b0;
            dataout_q   <= '0;
            data_rdy_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the pre-edge values, independent of statement order.
            state_q     <= state_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            diff_q      <= diff_d;
            k_q         <= k_d;
            gap_q       <= gap_d;
            rate_l_q    <= rate_l_d;
            hold_data_q <= hold_data_d;
            hold_vld_q  <= hold_vld_d;
            dataout_q   <= dataout_d;
            data_rdy_q  <= data_rdy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.dataout  = dataout_q;
    assign bus.data_rdy = data_rdy_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_cu_dac_interpolation.sv
// Self-checking bench for cu_dac_interpolation.
// Input samples are driven through the interface. A behavioural model predicts
// every output value and the cycle at which it appears, and pushes both into a
// scoreboard queue. A negedge monitor pops the queue on each data_rdy strobe.
module tb_cu_dac_interpolation;

    localparam int GAP = 4;

    logic clk = 1'b0;
    logic rst;

    cu_dac_interpolation_if bus();

    cu_dac_interpolation #(.GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int total     = 0;
    int bad       = 0;
    int cyc       = 0;
    int n_strobes = 0;

    // Model state: last burst target, cycle of the last scheduled strobe, hold buffer.
    int m_prev       = 0;
    int m_end        = -100;
    bit hold_pending = 1'b0;
    int hold_val     = 0;
    int cur_rate     = 0;

    // Count rising edges. At a negedge, cyc is the index of the edge just past.
    always @(posedge clk) cyc <= cyc + 1;

    // Compare each output strobe with the oldest scoreboard entry.
    always @(negedge clk) begin
        if (bus.data_rdy === 1'b1) begin
            n_strobes++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: dataout=%0d at cycle %0d, no output required",
                         $signed(bus.dataout), cyc);
            end else begin
                mon_e = sb.pop_front();
                if (bus.dataout !== mon_e.val || cyc !== mon_e.cyc) begin
                    bad++;
                    $display("FAIL strobe: got dataout=%0d at cycle %0d, required dataout=%0d at cycle %0d",
                             $signed(bus.dataout), cyc, $signed(mon_e.val), mon_e.cyc);
                end
            end
        end
    end

    function automatic int floor_div(int num, int n);
        int q;
        q = num / n;
        if ((num % n != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    // Predict one burst: N outputs ramping from m_prev to value, GAP clocks apart.
    task automatic schedule(int value, int r, int first);
        int   n;
        int   d;
        exp_t e;
        n = 1 << r;
        d = value - m_prev;
        for (int k = 1; k <= n; k++) begin
            e.val = 16'(m_prev + floor_div(d * k, n));
            e.cyc = first + (k - 1) * GAP;
            sb.push_back(e);
        end
        m_prev = value;
        m_end  = first + (n - 1) * GAP;
    endtask

    // Drive one drdy pulse. Call at a negedge; returns at the next negedge.
    // Rate is kept constant while a held sample is pending.
    task automatic send(int v, int r);
        int c;
        bus.rate   = 3'(r);
        bus.datain = 16'(v);
        bus.drdy   = 1'b1;
        cur_rate   = r;
        c          = cyc + 1;
        if (hold_pending && c > m_end) begin
            schedule(hold_val, cur_rate, m_end + 2);
            hold_pending = 1'b0;
        end
        if (c > m_end) begin
            schedule(v, r, c + 2);
        end else if (c == m_end) begin
            if (hold_pending) begin
                schedule(hold_val, r, c + 2);
                hold_val = v;
            end else begin
                schedule(v, r, c + 2);
            end
        end else if (!hold_pending) begin
            hold_pending = 1'b1;
            hold_val     = v;
        end
        @(negedge clk);
        bus.drdy = 1'b0;
    endtask

    // Flush any held sample into the model, then wait for the DUT to go quiet.
    task automatic wait_idle();
        int n;
        n = 0;
        if (hold_pending) begin
            schedule(hold_val, cur_rate, m_end + 2);
            hold_pending = 1'b0;
        end
        while ((sb.size() != 0 || bus.busy !== 1'b0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sb.size() != 0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL drain: %0d outputs still pending, busy=%b after %0d cycles, required 0 pending and busy=0",
                     sb.size(), bus.busy, n);
        end
    endtask

    task automatic check_bit(string name, logic got, logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        bus.drdy   = 1'b0;
        bus.datain = '0;
        bus.rate   = '0;
        repeat (3) @(negedge clk);
        check_int("reset_dataout", int'(bus.dataout), 0);
        check_bit("reset_data_rdy", bus.data_rdy, 1'b0);
        check_bit("reset_busy", bus.busy, 1'b0);
        check_bit("reset_overrun", bus.overrun, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_bit("post_release_busy", bus.busy, 1'b0);
    endtask

    task automatic test_ramp();
        int base;
        base = n_strobes;
        send(100, 2);
        check_bit("busy_in_burst", bus.busy, 1'b1);
        wait_idle();
        check_int("ramp_up_count", n_strobes - base, 4);
        send(-100, 2);
        wait_idle();
        check_int("ramp_down_count", n_strobes - base, 8);
    endtask

    task automatic test_floor();
        send(10, 0);
        wait_idle();
        send(9, 1);
        wait_idle();
        send(-32768, 0);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        send(300, 1);
        send(200, 1);
        while (cyc + 1 < m_end) @(negedge clk);
        send(-500, 1);
        wait_idle();
        check_bit("b2b_no_overrun", bus.overrun, 1'b0);
    endtask

    task automatic test_overrun();
        int base;
        base = n_strobes;
        send(2000, 3);
        repeat (4) @(negedge clk);
        send(1500, 3);
        check_bit("held_no_overrun", bus.overrun, 1'b0);
        repeat (2) @(negedge clk);
        send(-1234, 3);
        check_bit("overrun_set", bus.overrun, 1'b1);
        wait_idle();
        check_int("overrun_strobe_count", n_strobes - base, 16);
        repeat (3) @(negedge clk);
        check_bit("overrun_sticky", bus.overrun, 1'b1);
    endtask

    task automatic test_reset_mid_burst();
        int base;
        int n;
        base = n_strobes;
        n    = 0;
        send(80, 2);
        while (n_strobes < base + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_int("strobes_before_reset", n_strobes - base, 2);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_int("midreset_dataout", int'(bus.dataout), 0);
        check_bit("midreset_data_rdy", bus.data_rdy, 1'b0);
        check_bit("midreset_busy", bus.busy, 1'b0);
        check_bit("midreset_overrun", bus.overrun, 1'b0);
        sb.delete();
        m_prev       = 0;
        m_end        = -100;
        hold_pending = 1'b0;
        base         = n_strobes;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check_int("no_strobe_after_reset", n_strobes - base, 0);
        send(40, 2);
        wait_idle();
        check_int("fresh_burst_count", n_strobes - base, 4);
    endtask

    task automatic test_rate_change();
        int base;
        base = n_strobes;
        send(1000, 2);
        @(negedge clk);
        bus.rate = 3'd0;
        cur_rate = 0;
        wait_idle();
        check_int("old_rate_burst_count", n_strobes - base, 4);
        send(-7, 0);
        wait_idle();
        check_int("new_rate_burst_count", n_strobes - base, 5);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_floor();
        test_back_to_back();
        test_overrun();
        test_reset_mid_burst();
        test_rate_change();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cu_dac_interpolation.md
CU_DAC_INTERPOLATION -- requirements
Module: cu_dac_interpolation

Interface
REQ-001 SHALL have parameter GAP, default 4: clocks between successive output strobes within a burst; legal range 1..255.
REQ-002 SHALL have port clk, input, 1: single system clock; all logic rising-edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port drdy, input, 1: one-cycle, clk-synchronous input-sample strobe.
REQ-005 SHALL have port datain, input, 16: signed two's-complement sample, valid when drdy=1.
REQ-006 SHALL have port rate, input, 3: interpolation factor N = 2^rate (1..128).
REQ-007 SHALL have port dataout, output, 16: signed interpolated sample, valid when data_rdy=1.
REQ-008 SHALL have port data_rdy, output, 1: one-cycle output strobe.
REQ-009 SHALL have port busy, output, 1: high whenever state != IDLE.
REQ-010 SHALL have port overrun, output, 1: sticky input-drop flag.

Function
REQ-011 SHALL hold registers prev[15:0], cur[15:0], diff[16:0], k[7:0], gap counter, rate_l[2:0], hold_data[15:0], hold_vld.
REQ-012 SHALL implement states IDLE, LOAD, EMIT, WAIT.
REQ-013 IDLE, drdy=1: cur <= datain, rate_l <= rate, go LOAD.
REQ-014 LOAD: diff <= cur - prev (17-bit signed), k <= 1, go EMIT.
REQ-015 EMIT: dataout <= prev + ((diff*k) >>> rate_l); data_rdy=1 for this single cycle.
REQ-016 Product SHALL be a 25-bit signed value; shift SHALL be arithmetic (floor toward -inf); the sum is truncated to 16 bits and never overflows, since the result lies between prev and cur.
REQ-017 EMIT with k < N: k <= k+1, go WAIT.
REQ-018 WAIT SHALL last GAP-1 cycles, then return to EMIT, so strobes are exactly GAP clocks apart; with GAP=1, WAIT is skipped.
REQ-019 EMIT with k = N: prev <= cur.
REQ-020 EMIT with k = N and hold_vld=1, or drdy=1 in that cycle: load that sample into cur, latch rate, clear hold_vld, go LOAD.
REQ-021 EMIT with k = N otherwise: go IDLE.
REQ-022 The final output of each burst (k=N) SHALL equal cur exactly.
REQ-023 Latency: drdy in IDLE at cycle t gives the first data_rdy at t+2.
REQ-024 drdy while busy (not at the final EMIT) with hold_vld=0: hold_data <= datain, hold_vld <= 1.
REQ-025 drdy while busy with hold_vld=1: the new sample is dropped and overrun <= 1; hold_data is unchanged.
REQ-026 drdy coincident with the final EMIT with hold_vld=1: the held sample is consumed, the new sample is written to hold, and no overrun occurs.
REQ-027 rate SHALL be sampled only at burst start; rate changes mid-burst SHALL NOT affect the current burst.
REQ-028 rate=0 SHALL give one output per input, equal to the input.
REQ-029 overrun SHALL clear only on reset.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE, dataout=0, data_rdy=0, busy=0, overrun=0, prev=0, cur=0, hold_vld=0, k=0.
REQ-031 rst asserted mid-burst SHALL abort the burst with no further data_rdy; after release the next drdy starts a fresh burst from prev=0.
REQ-032 Reset release SHALL take effect at the next rising clk edge; there SHALL be no strobe on the release cycle.

Verification
REQ-033 After reset, GAP=4, rate=2, drdy with datain=100 -> data_rdy at t+2, t+6, t+10, t+14 with dataout 25, 50, 75, 100.
REQ-034 Then rate=2, datain=-100 -> outputs 50, 0, -50, -100.
REQ-035 rate=1, prev=10, datain=9 -> outputs 9, 9 (floor check); rate=0, datain=-32768 -> single output -32768.
REQ-036 rate=3 burst in progress, two drdy pulses mid-burst -> first is held and played after the burst (its first strobe 2 clocks after the last strobe); second sets overrun=1 and is never output.
REQ-037 rst=0 between the 2nd and 3rd strobe of a rate=2 burst -> all outputs 0 at once, no further strobes; next drdy datain=40 -> 10, 20, 30, 40.
REQ-038 rate changed from 2 to 0 during a burst -> current burst still gives 4 strobes; the next sample gives 1 strobe.
